// File: rtl/bm_pkg.sv
// bm_pkg: shared constants, FSM state type and tile-to-pixel helper for the sprite controller.
package bm_pkg;
    localparam int TILE_PX = 16;
    localparam int COL_W = 3;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [COL_W-1:0] COL_TRANSPARENT = 3'b000;

    typedef enum logic {IDLE, MOVING} state_t;

    function automatic logic [9:0] tile_px(input int origin, input logic [3:0] t);
        return 10'(origin + TILE_PX * int'(t));
    endfunction
endpackage

// File: rtl/man_motion.sv
// man_motion: tile-move FSM, pixel position/display registers and bounds check.
// Optional MAN_FACING_EN adds a facing_left register driven by accepted left/right moves.
module man_motion
    import bm_pkg::*;
#(
    parameter int GRID_W    = 15,
    parameter int GRID_H    = 13,
    parameter int ORIGIN_X  = 80,
    parameter int ORIGIN_Y  = 32,
    parameter int START_COL = 1,
    parameter int START_ROW = 1,
    parameter int STEP_PX   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       move_req,
    input  logic [1:0] move_dir,
    input  logic       move_blocked,
    output logic       busy,
    output logic [3:0] tile_col,
    output logic [3:0] tile_row,
`ifdef MAN_FACING_EN
    output logic       facing_left,
`endif
    output logic [9:0] disp_x,
    output logic [9:0] disp_y
);
    localparam logic [3:0] START_C = 4'(START_COL);
    localparam logic [3:0] START_R = 4'(START_ROW);
    localparam logic [9:0] START_X = 10'(ORIGIN_X + TILE_PX * START_COL);
    localparam logic [9:0] START_Y = 10'(ORIGIN_Y + TILE_PX * START_ROW);
    localparam logic [9:0] STEP    = 10'(STEP_PX);

    state_t     r_state;
    logic [9:0] r_pos_x, r_pos_y, r_disp_x, r_disp_y, r_tgt_px;
    logic [3:0] r_col, r_row, r_tgt_col, r_tgt_row;
    logic [1:0] r_dir;
    logic [3:0] w_tcol, w_trow;
    logic [9:0] w_cur, w_step, w_nx, w_ny;
    logic       w_ok, w_accept, w_adv, w_arrive;

    always_comb begin
        w_tcol   = move_dir == DIR_LEFT ? r_col - 4'd1 : move_dir == DIR_RIGHT ? r_col + 4'd1 : r_col;
        w_trow   = move_dir == DIR_UP ? r_row - 4'd1 : move_dir == DIR_DOWN ? r_row + 4'd1 : r_row;
        w_ok     = move_dir == DIR_UP   ? r_row != 4'd0 :
                   move_dir == DIR_DOWN ? int'(r_row) + 1 < GRID_H :
                   move_dir == DIR_LEFT ? r_col != 4'd0 : int'(r_col) + 1 < GRID_W;
        w_accept = r_state == IDLE && move_req && !move_blocked && w_ok;
        // dir bit1 selects the x axis, bit0 selects increasing coordinate
        w_cur    = r_dir[1] ? r_pos_x : r_pos_y;
        w_step   = r_dir[0] ? w_cur + STEP : w_cur - STEP;
        w_adv    = r_state == MOVING && frame_tick;
        w_arrive = w_adv && w_step == r_tgt_px;
        w_nx     = w_adv && r_dir[1] ? w_step : r_pos_x;
        w_ny     = w_adv && !r_dir[1] ? w_step : r_pos_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pos_x   <= START_X;
            r_pos_y   <= START_Y;
            r_disp_x  <= START_X;
            r_disp_y  <= START_Y;
            r_col     <= START_C;
            r_row     <= START_R;
            r_tgt_col <= START_C;
            r_tgt_row <= START_R;
            r_tgt_px  <= START_X;
            r_dir     <= DIR_UP;
        end else begin
            if (w_accept) begin
                r_state   <= MOVING;
                r_dir     <= move_dir;
                r_tgt_col <= w_tcol;
                r_tgt_row <= w_trow;
                r_tgt_px  <= move_dir[1] ? tile_px(ORIGIN_X, w_tcol) : tile_px(ORIGIN_Y, w_trow);
            end
            if (w_arrive) begin
                r_state <= IDLE;
                r_col   <= r_tgt_col;
                r_row   <= r_tgt_row;
            end
            r_pos_x <= w_nx;
            r_pos_y <= w_ny;
            if (frame_tick) begin
                r_disp_x <= w_nx;
                r_disp_y <= w_ny;
            end
        end
    end

`ifdef MAN_FACING_EN
    logic r_facing;
    always_ff @(posedge clk) begin
        if (rst)
            r_facing <= 1'b0;
        else if (w_accept && move_dir[1])
            r_facing <= !move_dir[0];
    end
    assign facing_left = r_facing;
`endif

    assign busy     = r_state == MOVING;
    assign tile_col = r_col;
    assign tile_row = r_row;
    assign disp_x   = r_disp_x;
    assign disp_y   = r_disp_y;
endmodule

// File: rtl/man_sprite_ctrl.sv
// man_sprite_ctrl: player sprite motion plus 2-stage mask/background compositing pipeline.
// Optional MAN_FACING_EN mirrors mask_px when the player faces left.
module man_sprite_ctrl
    import bm_pkg::*;
#(
    parameter int GRID_W    = 15,
    parameter int GRID_H    = 13,
    parameter int ORIGIN_X  = 80,
    parameter int ORIGIN_Y  = 32,
    parameter int START_COL = 1,
    parameter int START_ROW = 1,
    parameter int STEP_PX   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             move_req,
    input  logic [1:0]       move_dir,
    input  logic             move_blocked,
    output logic             busy,
    output logic [3:0]       tile_col,
    output logic [3:0]       tile_row,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             video_on,
    input  logic [COL_W-1:0] bg_col,
    output logic [9:0]       mask_px,
    output logic [9:0]       mask_py,
    input  logic [COL_W-1:0] mask_col,
    output logic [COL_W-1:0] pix_col,
    output logic             sprite_hit
);
    logic [9:0]       w_disp_x, w_disp_y, w_dx, w_dy, w_px;
    logic             w_in_box, w_draw;
    logic [9:0]       r_mask_px, r_mask_py;
    logic             r_in_box, r_von, r_hit;
    logic [COL_W-1:0] r_bg, r_pix;
`ifdef MAN_FACING_EN
    logic             w_facing;
`endif

    man_motion #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
        .START_COL(START_COL), .START_ROW(START_ROW), .STEP_PX(STEP_PX)
    ) u_motion (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_req(move_req),
        .move_dir(move_dir), .move_blocked(move_blocked), .busy(busy),
        .tile_col(tile_col), .tile_row(tile_row),
`ifdef MAN_FACING_EN
        .facing_left(w_facing),
`endif
        .disp_x(w_disp_x), .disp_y(w_disp_y)
    );

    // Wrapping subtraction turns pixels left of / above the sprite into large values
    always_comb begin
        w_dx     = hcount - w_disp_x;
        w_dy     = vcount - w_disp_y;
        w_in_box = video_on && w_dx < 10'(TILE_PX) && w_dy < 10'(TILE_PX);
`ifdef MAN_FACING_EN
        w_px     = w_facing ? 10'd15 - w_dx : w_dx;
`else
        w_px     = w_dx;
`endif
        w_draw   = r_von && r_in_box && mask_col != COL_TRANSPARENT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask_px <= '0;
            r_mask_py <= '0;
            r_in_box  <= 1'b0;
            r_von     <= 1'b0;
            r_bg      <= '0;
            r_pix     <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_mask_px <= w_in_box ? w_px : '0;
            r_mask_py <= w_in_box ? w_dy : '0;
            r_in_box  <= w_in_box;
            r_von     <= video_on;
            r_bg      <= bg_col;
            r_pix     <= !r_von ? '0 : w_draw ? mask_col : r_bg;
            r_hit     <= w_draw;
        end
    end

    assign mask_px    = r_mask_px;
    assign mask_py    = r_mask_py;
    assign pix_col    = r_pix;
    assign sprite_hit = r_hit;
endmodule

// File: tb/tb_man_sprite_ctrl.sv
// tb_man_sprite_ctrl: directed checks of motion FSM, bounds/blocking and the pixel pipeline.
module tb_man_sprite_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       move_req = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic       move_blocked = 1'b0;
    logic       busy;
    logic [3:0] tile_col, tile_row;
    logic [9:0] hcount = '0, vcount = '0;
    logic       video_on = 1'b0;
    logic [2:0] bg_col = '0;
    logic [9:0] mask_px, mask_py;
    logic [2:0] mask_col = '0;
    logic [2:0] pix_col;
    logic       sprite_hit;
    int         n_pass = 0;
    int         n_total = 0;

    man_sprite_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .move_req(move_req),
        .move_dir(move_dir), .move_blocked(move_blocked), .busy(busy),
        .tile_col(tile_col), .tile_row(tile_row), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .bg_col(bg_col), .mask_px(mask_px), .mask_py(mask_py),
        .mask_col(mask_col), .pix_col(pix_col), .sprite_hit(sprite_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        move_req = 1'b0;
        frame_tick = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] dir);
        bit done = 0;
        move_dir = dir;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!busy) done = 1;
            else begin
                frame_tick = 1'b1;
                tick();
                frame_tick = 1'b0;
                tick();
            end
        end
        chk("move_completes", int'(busy), 0);
    endtask

    task automatic test_reset();
        video_on = 1'b0;
        do_reset();
        tick();
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_tile_col", int'(tile_col), 1);
        chk("reset_tile_row", int'(tile_row), 1);
        chk("reset_pix_col", int'(pix_col), 0);
        chk("reset_hit", int'(sprite_hit), 0);
        hcount = 10'd111;
        vcount = 10'd63;
        video_on = 1'b1;
        tick();
        chk("reset_pos_px", int'(mask_px), 15);
        chk("reset_pos_py", int'(mask_py), 15);
        hcount = 10'd112;
        tick();
        chk("reset_pos_right_edge", int'(mask_px), 0);
    endtask

    task automatic test_move_right();
        move_dir = 2'd3;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        chk("right_busy_start", int'(busy), 1);
        hcount = 10'd112;
        vcount = 10'd50;
        video_on = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
            chk($sformatf("right_dx_tick%0d", k), int'(mask_px), 16 - k);
            chk($sformatf("right_busy_tick%0d", k), int'(busy), k < 16 ? 1 : 0);
        end
        chk("right_py", int'(mask_py), 2);
        chk("right_tile_col", int'(tile_col), 2);
        chk("right_tile_row", int'(tile_row), 1);
    endtask

    task automatic test_ignored();
        do_move(2'd0);
        chk("up_tile_row", int'(tile_row), 0);
        move_dir = 2'd0;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        tick();
        chk("up_at_row0_busy", int'(busy), 0);
        chk("up_at_row0_row", int'(tile_row), 0);
        move_dir = 2'd2;
        move_blocked = 1'b1;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        move_blocked = 1'b0;
        tick();
        chk("blocked_busy", int'(busy), 0);
        chk("blocked_col", int'(tile_col), 2);
        hcount = 10'd112;
        vcount = 10'd32;
        video_on = 1'b1;
        tick();
        chk("blocked_pos_px", int'(mask_px), 0);
        hcount = 10'd127;
        tick();
        chk("blocked_pos_px15", int'(mask_px), 15);
    endtask

    task automatic test_pixel();
        do_reset();
        hcount = 10'd100;
        vcount = 10'd50;
        video_on = 1'b1;
        bg_col = 3'b010;
        mask_col = 3'b101;
        tick();
        chk("pix_mask_px", int'(mask_px), 4);
        chk("pix_mask_py", int'(mask_py), 2);
        tick();
        chk("pix_sprite_col", int'(pix_col), 5);
        chk("pix_sprite_hit", int'(sprite_hit), 1);
        mask_col = 3'b000;
        tick();
        chk("pix_transparent_col", int'(pix_col), 2);
        chk("pix_transparent_hit", int'(sprite_hit), 0);
    endtask

    task automatic test_box_edges();
        mask_col = 3'b101;
        bg_col = 3'b110;
        vcount = 10'd50;
        video_on = 1'b1;
        hcount = 10'd95;
        tick();
        chk("left_edge_px", int'(mask_px), 0);
        tick();
        chk("left_edge_col", int'(pix_col), 6);
        chk("left_edge_hit", int'(sprite_hit), 0);
        hcount = 10'd112;
        tick();
        chk("right_edge_px", int'(mask_px), 0);
        tick();
        chk("right_edge_col", int'(pix_col), 6);
        chk("right_edge_hit", int'(sprite_hit), 0);
        hcount = 10'd100;
        video_on = 1'b0;
        tick();
        tick();
        chk("blank_col", int'(pix_col), 0);
        chk("blank_hit", int'(sprite_hit), 0);
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        move_dir = 2'd2;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        chk("left_accept_busy", int'(busy), 1);
        hcount = 10'd96;
        vcount = 10'd48;
        video_on = 1'b1;
        tick();
`ifdef MAN_FACING_EN
        chk("facing_mirror_px", int'(mask_px), 15);
`else
        chk("no_mirror_px", int'(mask_px), 0);
`endif
        repeat (3) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
        chk("mid_move_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hcount = 10'd97;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_col", int'(tile_col), 1);
        chk("mid_reset_row", int'(tile_row), 1);
        tick();
        chk("mid_reset_px_unmirrored", int'(mask_px), 1);
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_ignored();
        test_pixel();
        test_box_edges();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
